// File: rtl/tinyalu_result_packer_pkg.sv
// rtl/tinyalu_result_packer_pkg.sv - shared record layout, limits and command state enum
package tinyalu_result_packer_pkg;

    localparam int REC_W   = 32;
    localparam int RES_LSB = 0;
    localparam int RES_W   = 16;
    localparam int OP_LSB  = 16;
    localparam int OP_W    = 3;
    localparam int LAT_LSB = 24;
    localparam int LAT_W   = 8;

    localparam logic [LAT_W-1:0] LAT_MAX = 8'd255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } cmd_state_t;

    // Bits [23:19] stay zero by construction.
    function automatic logic [REC_W-1:0] make_record(
        input logic [LAT_W-1:0] lat,
        input logic [OP_W-1:0]  op,
        input logic [RES_W-1:0] res
    );
        logic [REC_W-1:0] r;
        r = '0;
        r[RES_LSB +: RES_W] = res;
        r[OP_LSB  +: OP_W]  = op;
        r[LAT_LSB +: LAT_W] = lat;
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_cmd_tracker.sv
// rtl/tinyalu_cmd_tracker.sv - ALU command FSM, latency counter, timeout and spurious-done tracking
module tinyalu_cmd_tracker
    import tinyalu_result_packer_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic              done_i,
    input  logic [RES_W-1:0]  result_i,
    output logic              rec_valid,
    output logic [REC_W-1:0]  rec_data,
    output logic [7:0]        spurious_cnt,
    output logic              timeout,
    output cmd_state_t        state_q
);

    logic [LAT_W-1:0] lat_q;
    logic [OP_W-1:0]  op_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            lat_q        <= '0;
            op_q         <= '0;
            rec_valid    <= 1'b0;
            rec_data     <= '0;
            spurious_cnt <= '0;
            timeout      <= 1'b0;
        end else begin
            rec_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (done_i && spurious_cnt != 8'hFF)
                        spurious_cnt <= spurious_cnt + 8'd1;
                    if (start_i) begin
                        op_q    <= op_i;
                        lat_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Recorded latency counts BUSY cycles including the done cycle.
                    if (done_i) begin
                        rec_valid <= 1'b1;
                        rec_data  <= make_record((lat_q == LAT_MAX) ? LAT_MAX : lat_q + 8'd1,
                                                 op_q, result_i);
                        state_q   <= ST_IDLE;
                    end else if (lat_q == LAT_MAX) begin
                        timeout <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        lat_q <= lat_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tinyalu_result_packer.sv
// rtl/tinyalu_result_packer.sv - packs ALU result records into wide packets with a held output stage
module tinyalu_result_packer
    import tinyalu_result_packer_pkg::*;
#(
    parameter  int TOTAL_WIDTH = 256,
    localparam int SLOTS       = TOTAL_WIDTH / 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [2:0]             op_i,
    input  logic                   done_i,
    input  logic [15:0]            result_i,
    input  logic                   flush_i,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic [TOTAL_WIDTH-1:0] pkt_data_o,
    output logic [3:0]             pkt_count_o,
    output logic [7:0]             drop_cnt_o,
    output logic [7:0]             spurious_cnt_o,
    output logic                   timeout_o
);

    localparam logic [3:0] SLOTS_C = 4'(SLOTS);

    logic                   rec_valid;
    logic [REC_W-1:0]       rec_data;
    cmd_state_t             cmd_state;
    logic [TOTAL_WIDTH-1:0] pack_q;
    logic [3:0]             cnt_q;
    logic                   flush_pend_q;
    logic                   pack_full;
    logic                   out_free;
    logic                   xfer;

    tinyalu_cmd_tracker u_tracker (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .op_i         (op_i),
        .done_i       (done_i),
        .result_i     (result_i),
        .rec_valid    (rec_valid),
        .rec_data     (rec_data),
        .spurious_cnt (spurious_cnt_o),
        .timeout      (timeout_o),
        .state_q      (cmd_state)
    );

    always_comb begin
        pack_full = (cnt_q == SLOTS_C);
        out_free  = !pkt_valid_o || pkt_ready_i;
        xfer      = out_free && (pack_full || (flush_pend_q && cnt_q != 4'd0));
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pack_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            pkt_valid_o  <= 1'b0;
            pkt_data_o   <= '0;
            pkt_count_o  <= '0;
            drop_cnt_o   <= '0;
        end else if (xfer) begin
            pkt_data_o   <= pack_q;
            pkt_count_o  <= cnt_q;
            pkt_valid_o  <= 1'b1;
            flush_pend_q <= 1'b0;
            // A record arriving now starts the freshly emptied buffer.
            if (rec_valid) begin
                pack_q <= TOTAL_WIDTH'(rec_data);
                cnt_q  <= 4'd1;
            end else begin
                pack_q <= '0;
                cnt_q  <= 4'd0;
            end
        end else begin
            if (pkt_valid_o && pkt_ready_i)
                pkt_valid_o <= 1'b0;
            if (rec_valid) begin
                if (pack_full) begin
                    if (drop_cnt_o != 8'hFF)
                        drop_cnt_o <= drop_cnt_o + 8'd1;
                end else begin
                    for (int s = 0; s < SLOTS; s++)
                        if (cnt_q == 4'(s))
                            pack_q[s*REC_W +: REC_W] <= rec_data;
                    cnt_q <= cnt_q + 4'd1;
                end
            end
            flush_pend_q <= (cnt_q != 4'd0) && (flush_pend_q || flush_i);
        end
    end

endmodule

// File: tb/tb_tinyalu_result_packer.sv
// tb/tb_tinyalu_result_packer.sv - self-checking bench for tinyalu_result_packer
module tb_tinyalu_result_packer;
    import tinyalu_result_packer_pkg::*;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic [2:0]   op_i;
    logic         done_i;
    logic [15:0]  result_i;
    logic         flush_i;
    logic         pkt_valid_o;
    logic         pkt_ready_i;
    logic [255:0] pkt_data_o;
    logic [3:0]   pkt_count_o;
    logic [7:0]   drop_cnt_o;
    logic [7:0]   spurious_cnt_o;
    logic         timeout_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] sb[$];
    logic [3:0]  pc_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [15:0] res;
        int          dly;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[11];

    tinyalu_result_packer #(.TOTAL_WIDTH(256)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .op_i           (op_i),
        .done_i         (done_i),
        .result_i       (result_i),
        .flush_i        (flush_i),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready_i),
        .pkt_data_o     (pkt_data_o),
        .pkt_count_o    (pkt_count_o),
        .drop_cnt_o     (drop_cnt_o),
        .spurious_cnt_o (spurious_cnt_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Handshake monitor: every accepted packet is compared against the scoreboard.
    always @(negedge clk) begin : mon
        logic [3:0] ec;
        if (reset_i === 1'b1 && pkt_valid_o && pkt_ready_i) begin
            if (pc_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_packet: got count %0d, required no packet", pkt_count_o);
            end else begin
                ec = pc_q.pop_front();
                check("pkt_count", 256'(pkt_count_o), 256'(ec));
                for (int s = 0; s < 8; s++) begin
                    if (s < int'(ec)) begin
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL slot_underflow: got %h, required no record", pkt_data_o[s*32 +: 32]);
                        end else begin
                            check("slot_data", 256'(pkt_data_o[s*32 +: 32]), 256'(sb.pop_front()));
                        end
                    end else begin
                        check("slot_zero", 256'(pkt_data_o[s*32 +: 32]), 256'(0));
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] res, input int dly,
                         input bit push, input logic [31:0] exp);
        @(posedge clk); #1;
        start_i = 1'b1;
        op_i    = op;
        if (push) sb.push_back(exp);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (dly - 1) @(posedge clk);
        #1;
        done_i   = 1'b1;
        result_i = res;
        @(posedge clk); #1;
        done_i   = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
    endtask

    task automatic check_drained(input string name);
        check({name, "_records"}, 256'(sb.size()), 256'(0));
        check({name, "_packets"}, 256'(pc_q.size()), 256'(0));
    endtask

    initial begin
        logic [255:0] exp_pkt;
        logic [31:0]  e;
        int           d;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{3'd1, 16'(16'h0010 + i), 3, 32'(32'h03010010 + i)};
        tbl[8]  = '{3'd5, 16'hBEEF, 1,  32'h0105BEEF};
        tbl[9]  = '{3'd7, 16'hFFFF, 10, 32'h0A07FFFF};
        tbl[10] = '{3'd0, 16'h1234, 2,  32'h02001234};

        reset_i = 1'b0; start_i = 1'b0; op_i = '0; done_i = 1'b0;
        result_i = '0; flush_i = 1'b0; pkt_ready_i = 1'b1;
        cycles(3);
        check("rst_valid", 256'(pkt_valid_o), 256'(0));
        check("rst_data", pkt_data_o, 256'(0));
        check("rst_count", 256'(pkt_count_o), 256'(0));
        check("rst_drop", 256'(drop_cnt_o), 256'(0));
        check("rst_spurious", 256'(spurious_cnt_o), 256'(0));
        check("rst_timeout", 256'(timeout_o), 256'(0));
        check("rst_fsm", 256'(dut.cmd_state), 256'(ST_IDLE));
        reset_i = 1'b1;

        // Full packet of eight fixed-latency commands.
        pc_q.push_back(4'd8);
        for (int i = 0; i < 8; i++)
            issue(tbl[i].op, tbl[i].res, tbl[i].dly, 1'b1, tbl[i].exp);
        cycles(10);
        check_drained("full");
        check("full_slot0", 256'(pkt_data_o[31:0]), 256'(32'h03010010));
        check("full_slot7", 256'(pkt_data_o[255:224]), 256'(32'h03010017));
        check("full_valid_fell", 256'(pkt_valid_o), 256'(0));

        // Partial packet via flush.
        pc_q.push_back(4'd3);
        for (int i = 8; i < 11; i++)
            issue(tbl[i].op, tbl[i].res, tbl[i].dly, 1'b1, tbl[i].exp);
        pulse_flush();
        cycles(10);
        check_drained("flush");
        check("flush_count", 256'(pkt_count_o), 256'(3));
        check("flush_pend_clr", 256'(dut.flush_pend_q), 256'(0));

        // Back-pressure: one packet held, eight buffered, one dropped.
        pkt_ready_i = 1'b0;
        exp_pkt = '0;
        pc_q.push_back(4'd8);
        pc_q.push_back(4'd8);
        for (int i = 0; i < 17; i++) begin
            d = 1 + (i % 4);
            e = {8'(d), 5'b0, 3'(i % 8), 16'(16'h0100 + i)};
            if (i < 8) exp_pkt[i*32 +: 32] = e;
            issue(3'(i % 8), 16'(16'h0100 + i), d, i < 16, e);
            if (i == 12) check("bp_hold_mid", pkt_data_o, exp_pkt);
        end
        cycles(4);
        check("bp_valid", 256'(pkt_valid_o), 256'(1));
        check("bp_hold_end", pkt_data_o, exp_pkt);
        check("bp_count", 256'(pkt_count_o), 256'(8));
        check("bp_buffered", 256'(dut.cnt_q), 256'(8));
        check("bp_drop", 256'(drop_cnt_o), 256'(1));
        pkt_ready_i = 1'b1;
        cycles(10);
        check_drained("bp");
        check("bp_empty", 256'(dut.cnt_q), 256'(0));

        // Timeout after 256 BUSY cycles without done.
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 3'd2;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (255) @(posedge clk);
        #1;
        check("to_not_yet", 256'(timeout_o), 256'(0));
        cycles(1);
        check("to_set", 256'(timeout_o), 256'(1));
        check("to_no_record", 256'(dut.cnt_q), 256'(0));
        check("to_idle", 256'(dut.cmd_state), 256'(ST_IDLE));
        pc_q.push_back(4'd1);
        issue(3'd3, 16'hA5A5, 4, 1'b1, 32'h0403A5A5);
        pulse_flush();
        cycles(10);
        check_drained("to");
        check("to_sticky", 256'(timeout_o), 256'(1));

        // Spurious done pulses while idle.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            done_i = 1'b1; result_i = 16'hDEAD;
            @(posedge clk); #1;
            done_i = 1'b0;
        end
        cycles(2);
        check("spur_cnt", 256'(spurious_cnt_o), 256'(2));
        check("spur_pack", 256'(dut.cnt_q), 256'(0));

        // Reset mid-command with five records buffered.
        for (int i = 0; i < 5; i++)
            issue(3'd6, 16'(i), 2, 1'b0, 32'h0);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 3'd4;
        @(posedge clk); #1;
        start_i = 1'b0;
        cycles(2);
        check("rm_buffered", 256'(dut.cnt_q), 256'(5));
        check("rm_busy", 256'(dut.cmd_state), 256'(ST_BUSY));
        #3 reset_i = 1'b0;
        #1;
        check("rm_valid", 256'(pkt_valid_o), 256'(0));
        check("rm_data", pkt_data_o, 256'(0));
        check("rm_count", 256'(pkt_count_o), 256'(0));
        check("rm_drop", 256'(drop_cnt_o), 256'(0));
        check("rm_spurious", 256'(spurious_cnt_o), 256'(0));
        check("rm_timeout", 256'(timeout_o), 256'(0));
        check("rm_pack", 256'(dut.cnt_q), 256'(0));
        check("rm_fsm", 256'(dut.cmd_state), 256'(ST_IDLE));
        @(posedge clk); #1;
        reset_i = 1'b1;
        pulse_flush();
        cycles(20);
        check("rm_no_packet", 256'(pkt_valid_o), 256'(0));
        check("rm_drop_after", 256'(drop_cnt_o), 256'(0));
        check_drained("rm");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
